// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter with message locking in front of the async FIFO write side.
// Ports: CLK/RST, per-requester Req_Valid/Req_Data/Req_Last/Req_Ready, FIFO_Full, W_INC/WR_DATA, Grant, Lock_Err, Stall_Cnt.
module fifo_wr_arbiter #(
  parameter int Data_Width   = 8,
  parameter int Num_Req      = 2,
  parameter int Lock_Timeout = 16,
  parameter int Cnt_Width    = 8
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [Num_Req-1:0]            Req_Valid,
  input  logic [Num_Req*Data_Width-1:0] Req_Data,
  input  logic [Num_Req-1:0]            Req_Last,
  output logic [Num_Req-1:0]            Req_Ready,
  input  logic                          FIFO_Full,
  output logic                          W_INC,
  output logic [Data_Width-1:0]         WR_DATA,
  output logic [Num_Req-1:0]            Grant,
  output logic                          Lock_Err,
  output logic [Cnt_Width-1:0]          Stall_Cnt
);

  localparam int PW = $clog2(Num_Req);
  localparam logic [7:0] TMO_MAX = 8'(Lock_Timeout - 1);

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } state_e;

  state_e             state_q;
  state_e             state_d;
  logic [PW-1:0]      rr_ptr_q;
  logic [PW-1:0]      rr_ptr_d;
  logic [PW-1:0]      owner_q;
  logic [PW-1:0]      owner_d;
  logic [PW-1:0]      sel;
  logic [PW-1:0]      cur;
  logic               any_vld;
  logic               eligible;
  logic [7:0]         tmo_q;
  logic [7:0]         tmo_d;
  logic [Num_Req-1:0] grant_d;
  logic               lock_err_d;

  // Scan from farthest to nearest so the last hit
  // is the first valid requester after rr_ptr.
  always_comb begin : p_sel
    int          idx;
    logic [PW-1:0] idx_p;
    sel     = '0;
    any_vld = 1'b0;
    idx     = 0;
    idx_p   = '0;
    for (int k = Num_Req; k >= 1; k--) begin
      idx   = (int'(rr_ptr_q) + k) % Num_Req;
      idx_p = PW'(idx);
      if (Req_Valid[idx_p]) begin
        sel     = idx_p;
        any_vld = 1'b1;
      end
    end
  end

  assign cur = (state_q == LOCK) ? owner_q : sel;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    tmo_d      = tmo_q;
    grant_d    = Grant;
    lock_err_d = 1'b0;
    eligible   = 1'b0;
    Req_Ready  = '0;
    W_INC      = 1'b0;
    WR_DATA    = Req_Data[int'(cur)*Data_Width +: Data_Width];

    unique case (state_q)
      ARB: begin
        eligible = any_vld;
        if (any_vld && !FIFO_Full) begin
          Req_Ready[sel] = 1'b1;
          W_INC          = 1'b1;
          if (Req_Last[sel]) begin
            rr_ptr_d = sel;
          end else begin
            state_d      = LOCK;
            owner_d      = sel;
            grant_d      = '0;
            grant_d[sel] = 1'b1;
            tmo_d        = '0;
          end
        end
      end
      LOCK: begin
        eligible = Req_Valid[owner_q];
        // Backpressure freezes the lock entirely,
        // so a full FIFO never counts as idle.
        if (!FIFO_Full) begin
          if (Req_Valid[owner_q]) begin
            Req_Ready[owner_q] = 1'b1;
            W_INC              = 1'b1;
            tmo_d              = '0;
            if (Req_Last[owner_q]) begin
              state_d  = ARB;
              rr_ptr_d = owner_q;
              grant_d  = '0;
            end
          end else if (tmo_q == TMO_MAX) begin
            state_d    = ARB;
            rr_ptr_d   = owner_q;
            grant_d    = '0;
            tmo_d      = '0;
            lock_err_d = 1'b1;
          end else begin
            tmo_d = tmo_q + 8'd1;
          end
        end
      end
    endcase

    if (RST) begin
      Req_Ready = '0;
      W_INC     = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ARB;
      rr_ptr_q  <= PW'(Num_Req - 1);
      owner_q   <= '0;
      tmo_q     <= '0;
      Grant     <= '0;
      Lock_Err  <= 1'b0;
      Stall_Cnt <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      tmo_q    <= tmo_d;
      Grant    <= grant_d;
      Lock_Err <= lock_err_d;
      if (FIFO_Full && eligible && (Stall_Cnt != '1)) begin
        Stall_Cnt <= Stall_Cnt + Cnt_Width'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: round-robin, locking, backpressure,
// timeout release, stall saturation and reset mid-message.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  vld;
  logic [15:0] dat;
  logic [1:0]  lst;
  logic [1:0]  rdy;
  logic        full;
  logic        winc;
  logic [7:0]  wdata;
  logic [1:0]  grant;
  logic        lock_err;
  logic [7:0]  stall;

  int n_cmp = 0;
  int n_err = 0;

  fifo_wr_arbiter #(
    .Data_Width  (8),
    .Num_Req     (2),
    .Lock_Timeout(16),
    .Cnt_Width   (8)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .Req_Valid(vld),
    .Req_Data (dat),
    .Req_Last (lst),
    .Req_Ready(rdy),
    .FIFO_Full(full),
    .W_INC    (winc),
    .WR_DATA  (wdata),
    .Grant    (grant),
    .Lock_Err (lock_err),
    .Stall_Cnt(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && full) chk("winc_full", 32'(winc), 32'h0);
  end

  initial begin
    #200us;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst  = 1'b1;
    vld  = 2'b00;
    lst  = 2'b00;
    full = 1'b0;
    dat  = {8'hB1, 8'hA0};
    cyc;
    cyc;
    vld = 2'b11;
    lst = 2'b11;
    #1;
    chk("rst_winc", 32'(winc), 32'h0);
    chk("rst_rdy", 32'(rdy), 32'h0);
    cyc;
    rst = 1'b0;
    #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_lerr", 32'(lock_err), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);

    for (int i = 0; i < 4; i++) begin
      chk("rr_rdy", 32'(rdy), (i % 2) ? 32'h2 : 32'h1);
      chk("rr_winc", 32'(winc), 32'h1);
      chk("rr_data", 32'(wdata), (i % 2) ? 32'hB1 : 32'hA0);
      cyc;
      #1;
    end

    chk("t2_pre", 32'(rdy), 32'h1);
    cyc;
    lst = 2'b01;
    #1;
    chk("t2_b1", 32'(rdy), 32'h2);
    cyc;
    #1;
    chk("t2_grant", 32'(grant), 32'h2);
    chk("t2_b2", 32'(rdy), 32'h2);
    chk("t2_b2d", 32'(wdata), 32'hB1);
    cyc;
    lst = 2'b11;
    #1;
    chk("t2_b3", 32'(rdy), 32'h2);
    chk("t2_grant3", 32'(grant), 32'h2);
    cyc;
    #1;
    chk("t2_grant0", 32'(grant), 32'h0);
    chk("t2_r0", 32'(rdy), 32'h1);
    chk("t2_r0d", 32'(wdata), 32'hA0);
    cyc;

    full = 1'b1;
    vld  = 2'b01;
    lst  = 2'b01;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_winc", 32'(winc), 32'h0);
      chk("t3_rdy", 32'(rdy), 32'h0);
      cyc;
    end
    full = 1'b0;
    #1;
    chk("t3_stall", 32'(stall), 32'd5);
    chk("t3_rel", 32'(winc), 32'h1);
    chk("t3_relr", 32'(rdy), 32'h1);
    cyc;

    lst = 2'b00;
    vld = 2'b01;
    #1;
    chk("t4_b1", 32'(rdy), 32'h1);
    cyc;
    vld = 2'b10;
    lst = 2'b11;
    for (int k = 0; k < 16; k++) begin
      #1;
      chk("t4_lerr0", 32'(lock_err), 32'h0);
      chk("t4_grant", 32'(grant), 32'h1);
      chk("t4_rdy0", 32'(rdy), 32'h0);
      cyc;
    end
    #1;
    chk("t4_lerr1", 32'(lock_err), 32'h1);
    chk("t4_grant0", 32'(grant), 32'h0);
    chk("t4_r1", 32'(rdy), 32'h2);
    chk("t4_r1d", 32'(wdata), 32'hB1);
    cyc;
    vld = 2'b00;
    #1;
    chk("t4_pulse", 32'(lock_err), 32'h0);

    full = 1'b1;
    vld  = 2'b01;
    repeat (300) cyc;
    #1;
    chk("t5_sat", 32'(stall), 32'd255);
    full = 1'b0;
    vld  = 2'b00;
    cyc;

    vld = 2'b10;
    lst = 2'b00;
    #1;
    chk("t6_b1", 32'(rdy), 32'h2);
    cyc;
    #1;
    chk("t6_grant", 32'(grant), 32'h2);
    rst = 1'b1;
    vld = 2'b11;
    #1;
    chk("t6_rwinc", 32'(winc), 32'h0);
    chk("t6_rrdy", 32'(rdy), 32'h0);
    cyc;
    rst = 1'b0;
    lst = 2'b11;
    #1;
    chk("t6_grant0", 32'(grant), 32'h0);
    chk("t6_stall0", 32'(stall), 32'h0);
    chk("t6_lerr0", 32'(lock_err), 32'h0);
    chk("t6_prio", 32'(rdy), 32'h1);
    chk("t6_data", 32'(wdata), 32'hA0);
    cyc;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
